// File: rtl/tap_regs.sv
// rtl/tap_regs.sv - JTAG TAP instruction register plus IDCODE/USER/BYPASS data chains
// Optional macro TAP_REGS_USER_CAPTURE_EN: USER capture loads user_din instead of user_q.
module tap_regs #(
  parameter logic [31:0] IDCODE = 32'h1234_5001,
  parameter int          USER_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tdi,
  input  logic              tlreset,
  input  logic              captureIR,
  input  logic              shiftIR,
  input  logic              captureDR,
  input  logic              shiftDR,
  input  logic              updateIR,
  input  logic              updateDR,
  input  logic [USER_W-1:0] user_din,
  output logic              tdo,
  output logic              tdo_en,
  output logic [3:0]        ir,
  output logic [USER_W-1:0] user_q,
  output logic              user_upd
);

  localparam logic [3:0]  IR_IDCODE  = 4'h1;
  localparam logic [3:0]  IR_USER    = 4'h8;
  localparam logic [3:0]  IR_CAPTURE = 4'b0101;
  localparam logic [31:0] ID_VALUE   = IDCODE | 32'h1;

  logic [3:0]        ir_q, ir_d;
  logic [3:0]        ir_sr_q, ir_sr_d;
  logic              byp_q, byp_d;
  logic [31:0]       id_sr_q, id_sr_d;
  logic [USER_W-1:0] usr_sr_q, usr_sr_d;
  logic [USER_W-1:0] user_reg_q, user_reg_d;
  logic              upd_q, upd_d;
  logic              tdo_q, tdo_d;
  logic              tdo_en_q, tdo_en_d;
  logic              sel_id, sel_usr, dr_bit0;
  logic [USER_W-1:0] usr_capture;

  // Unlisted instruction codes fall through to BYPASS.
  assign sel_id  = (ir_q == IR_IDCODE);
  assign sel_usr = (ir_q == IR_USER);
  assign dr_bit0 = sel_usr ? usr_sr_q[0] : (sel_id ? id_sr_q[0] : byp_q);

`ifdef TAP_REGS_USER_CAPTURE_EN
  assign usr_capture = user_din;
`else
  logic unused_user_din;
  assign unused_user_din = ^user_din;
  assign usr_capture     = user_reg_q;
`endif

  always_comb begin
    ir_d    = ir_q;
    ir_sr_d = ir_sr_q;
    if (tlreset) begin
      ir_d = IR_IDCODE;
    end else if (captureIR) begin
      ir_sr_d = IR_CAPTURE;
    end else if (shiftIR) begin
      ir_sr_d = {tdi, ir_sr_q[3:1]};
    end else if (updateIR) begin
      ir_d = ir_sr_q;
    end
  end

  // DR selection uses ir_q, so a same-edge IR update cannot retarget it.
  always_comb begin
    byp_d      = byp_q;
    id_sr_d    = id_sr_q;
    usr_sr_d   = usr_sr_q;
    user_reg_d = user_reg_q;
    upd_d      = 1'b0;
    if (captureDR) begin
      if (sel_usr)     usr_sr_d = usr_capture;
      else if (sel_id) id_sr_d  = ID_VALUE;
      else             byp_d    = 1'b0;
    end else if (shiftDR) begin
      if (sel_usr)     usr_sr_d = {tdi, usr_sr_q[USER_W-1:1]};
      else if (sel_id) id_sr_d  = {tdi, id_sr_q[31:1]};
      else             byp_d    = tdi;
    end else if (updateDR && sel_usr) begin
      user_reg_d = usr_sr_q;
      upd_d      = 1'b1;
    end
  end

  always_comb begin
    tdo_d    = tdo_q;
    tdo_en_d = 1'b0;
    if (shiftIR) begin
      tdo_d    = ir_sr_q[0];
      tdo_en_d = 1'b1;
    end else if (shiftDR) begin
      tdo_d    = dr_bit0;
      tdo_en_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_q       <= IR_IDCODE;
      ir_sr_q    <= IR_CAPTURE;
      byp_q      <= 1'b0;
      id_sr_q    <= '0;
      usr_sr_q   <= '0;
      user_reg_q <= '0;
      upd_q      <= 1'b0;
    end else begin
      ir_q       <= ir_d;
      ir_sr_q    <= ir_sr_d;
      byp_q      <= byp_d;
      id_sr_q    <= id_sr_d;
      usr_sr_q   <= usr_sr_d;
      user_reg_q <= user_reg_d;
      upd_q      <= upd_d;
    end
  end

  // tdo launches on the falling edge so the capturing device sees it stable at the next rise.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_en_q <= tdo_en_d;
    end
  end

  assign tdo      = tdo_q;
  assign tdo_en   = tdo_en_q;
  assign ir       = ir_q;
  assign user_q   = user_reg_q;
  assign user_upd = upd_q;

endmodule

// File: tb/tb_tap_regs.sv
// tb/tb_tap_regs.sv - directed self-checking bench for tap_regs
module tb_tap_regs;

  localparam logic [31:0] ID_VAL   = 32'h1234_5001;
  localparam logic [31:0] USER_VAL = 32'hDEAD_BEEF;
  localparam logic [31:0] DIN_VAL  = 32'hA5A5_0F0F;
`ifdef TAP_REGS_USER_CAPTURE_EN
  localparam logic [31:0] CAP_EXP  = DIN_VAL;
`else
  localparam logic [31:0] CAP_EXP  = USER_VAL;
`endif
  localparam int P_CIR = 0, P_UIR = 1, P_CDR = 2, P_UDR = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        tdi = 1'b0, tlreset = 1'b0;
  logic        captureIR = 1'b0, shiftIR = 1'b0, captureDR = 1'b0, shiftDR = 1'b0;
  logic        updateIR = 1'b0, updateDR = 1'b0;
  logic [31:0] user_din = '0;
  logic        tdo, tdo_en, user_upd;
  logic [3:0]  ir;
  logic [31:0] user_q;
  int          errors = 0;
  int          checks = 0;
  logic [63:0] w;
  logic [3:0]  ir_exp;

  tap_regs #(.IDCODE(32'h1234_5001), .USER_W(32)) dut (
    .clk(clk), .reset(reset), .tdi(tdi), .tlreset(tlreset),
    .captureIR(captureIR), .shiftIR(shiftIR), .captureDR(captureDR), .shiftDR(shiftDR),
    .updateIR(updateIR), .updateDR(updateDR), .user_din(user_din),
    .tdo(tdo), .tdo_en(tdo_en), .ir(ir), .user_q(user_q), .user_upd(user_upd)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input int k);
    case (k)
      P_CIR:   captureIR = 1'b1;
      P_UIR:   updateIR  = 1'b1;
      P_CDR:   captureDR = 1'b1;
      default: updateDR  = 1'b1;
    endcase
    @(posedge clk); #1;
    captureIR = 1'b0; updateIR = 1'b0; captureDR = 1'b0; updateDR = 1'b0;
  endtask

  task automatic set_ir(input logic [3:0] v);
    pulse(P_CIR);
    for (int i = 0; i < 4; i++) begin
      tdi = v[i]; shiftIR = 1'b1;
      @(posedge clk); #1;
    end
    shiftIR = 1'b0; tdi = 1'b0;
    pulse(P_UIR);
  endtask

  task automatic shift_dr(input logic [63:0] din, input int n, output logic [63:0] dout);
    dout = '0;
    for (int i = 0; i < n; i++) begin
      tdi = din[i]; shiftDR = 1'b1;
      @(negedge clk); #1;
      dout[i] = tdo;
      chk("tdo_en_during_shift", {63'd0, tdo_en}, 64'd1);
      @(posedge clk); #1;
    end
    shiftDR = 1'b0; tdi = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b1;
    #1;
    chk("reset_ir", {60'd0, ir}, 64'h1);
    chk("reset_user_q", {32'd0, user_q}, 64'd0);
    chk("reset_user_upd", {63'd0, user_upd}, 64'd0);
    chk("reset_tdo", {63'd0, tdo}, 64'd0);
    chk("reset_tdo_en", {63'd0, tdo_en}, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("ir_after_deassert", {60'd0, ir}, 64'h1);

    // IDCODE capture and full readout
    pulse(P_CDR);
    shift_dr(64'd0, 32, w);
    chk("idcode_word", w, {32'd0, ID_VAL});
    @(negedge clk); #1;
    chk("tdo_en_idle", {63'd0, tdo_en}, 64'd0);
    chk("tdo_hold_idle", {63'd0, tdo}, {63'd0, ID_VAL[31]});
    @(posedge clk); #1;

    // IR capture pattern, then BYPASS one-bit delay
    ir_exp = 4'b0101;
    pulse(P_CIR);
    for (int i = 0; i < 4; i++) begin
      tdi = 1'b1; shiftIR = 1'b1;
      @(negedge clk); #1;
      chk("ir_shift_tdo", {63'd0, tdo}, {63'd0, ir_exp[i]});
      chk("ir_shift_tdo_en", {63'd0, tdo_en}, 64'd1);
      @(posedge clk); #1;
    end
    shiftIR = 1'b0; tdi = 1'b0;
    pulse(P_UIR);
    chk("ir_bypass", {60'd0, ir}, 64'hF);
    pulse(P_CDR);
    shift_dr(64'b101, 3, w);
    chk("bypass_delay", w, 64'b010);

    // USER shift and update
    set_ir(4'h8);
    chk("ir_user", {60'd0, ir}, 64'h8);
    shift_dr({32'd0, USER_VAL}, 32, w);
    chk("user_upd_before", {63'd0, user_upd}, 64'd0);
    pulse(P_UDR);
    chk("user_q_update", {32'd0, user_q}, {32'd0, USER_VAL});
    chk("user_upd_pulse", {63'd0, user_upd}, 64'd1);
    @(posedge clk); #1;
    chk("user_upd_drop", {63'd0, user_upd}, 64'd0);

    // USER capture source
    user_din = DIN_VAL;
    pulse(P_CDR);
    shift_dr(64'd0, 32, w);
    chk("user_capture_word", w, {32'd0, CAP_EXP});
    chk("user_q_kept", {32'd0, user_q}, {32'd0, USER_VAL});

    // Same-edge updateIR must not retarget captureDR
    pulse(P_CIR);
    for (int i = 0; i < 4; i++) begin
      tdi = (i == 0); shiftIR = 1'b1;
      @(posedge clk); #1;
    end
    shiftIR = 1'b0; tdi = 1'b0;
    updateIR = 1'b1; captureDR = 1'b1;
    @(posedge clk); #1;
    updateIR = 1'b0; captureDR = 1'b0;
    chk("ir_same_edge", {60'd0, ir}, 64'h1);
    set_ir(4'h8);
    shift_dr(64'd0, 32, w);
    chk("capture_old_ir", w, {32'd0, CAP_EXP});

    // tlreset wins over updateIR
    tlreset = 1'b1; updateIR = 1'b1;
    @(posedge clk); #1;
    tlreset = 1'b0; updateIR = 1'b0;
    chk("tlreset_ir", {60'd0, ir}, 64'h1);
    chk("tlreset_user_q", {32'd0, user_q}, {32'd0, USER_VAL});
    pulse(P_UDR);
    chk("idcode_updr_upd", {63'd0, user_upd}, 64'd0);
    chk("idcode_updr_q", {32'd0, user_q}, {32'd0, USER_VAL});

    // Reset mid-shift
    set_ir(4'h8);
    pulse(P_CDR);
    for (int i = 0; i < 10; i++) begin
      tdi = 1'b1; shiftDR = 1'b1;
      @(posedge clk); #1;
    end
    chk("pre_reset_tdo_en", {63'd0, tdo_en}, 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_reset_ir", {60'd0, ir}, 64'h1);
    chk("mid_reset_user_q", {32'd0, user_q}, 64'd0);
    chk("mid_reset_user_upd", {63'd0, user_upd}, 64'd0);
    chk("mid_reset_tdo", {63'd0, tdo}, 64'd0);
    chk("mid_reset_tdo_en", {63'd0, tdo_en}, 64'd0);
    shiftDR = 1'b0; tdi = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_user_upd", {63'd0, user_upd}, 64'd0);
    chk("post_reset_ir", {60'd0, ir}, 64'h1);
    chk("post_reset_user_q", {32'd0, user_q}, 64'd0);
    @(negedge clk); #1;
    chk("post_reset_tdo_en", {63'd0, tdo_en}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tap_regs.md
TAP_REGS -- requirements
Module: tap_regs

Interface
REQ-001 SHALL have parameter IDCODE, default 32'h1234_5001, 32-bit identification value; bit 0 is forced to 1.
REQ-002 SHALL have parameter USER_W, default 32, width of the user data register (range 2..64).
REQ-003 SHALL have port clk  input  1  TCK; the only clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port tdi  input  1  serial test data in.
REQ-006 SHALL have port tlreset  input  1  high while the TAP is in Test-Logic-Reset.
REQ-007 SHALL have ports captureIR, shiftIR, captureDR, shiftDR  input  1 each  TAP state qualifiers.
REQ-008 SHALL have ports updateIR, updateDR  input  1 each  update strobes.
REQ-009 SHALL have port user_din  input  USER_W  parallel capture data for USER.
REQ-010 SHALL have port tdo  output  1  serial test data out.
REQ-011 SHALL have port tdo_en  output  1  tdo valid (output driver enable).
REQ-012 SHALL have port ir  output  4  current (updated) instruction.
REQ-013 SHALL have port user_q  output  USER_W  updated USER register contents.
REQ-014 SHALL have port user_upd  output  1  one-cycle pulse after a USER update.

Function
REQ-015 SHALL decode ir as: 4'h1 IDCODE, 4'h8 USER, 4'hF BYPASS; every other code selects BYPASS.
REQ-016 SHALL, on a rising clk with captureIR=1, load the IR shift register with 4'b0101.
REQ-017 SHALL, on a rising clk with shiftIR=1, shift the IR shift register right: tdi enters bit 3, bit 0 is discarded.
REQ-018 SHALL, on a rising clk with updateIR=1, copy the IR shift register to ir.
REQ-019 SHALL, on a rising clk with tlreset=1, set ir to 4'h1, overriding any other IR action that cycle.
REQ-020 SHALL give the DR chains the same capture/shift semantics on captureDR/shiftDR, acting only on the chain selected by ir:
  - BYPASS (1 bit): capture 0.
  - IDCODE (32 bit): capture IDCODE.
  - USER (USER_W bit): capture per REQ-030.
REQ-021 SHALL, on a rising clk with updateDR=1 and ir=USER, copy the USER shift register to user_q and assert user_upd for exactly that next cycle; in all other cycles user_upd SHALL be 0.
REQ-022 SHALL ignore updateDR for IDCODE and BYPASS.
REQ-023 SHALL update tdo and tdo_en on the falling clk edge only:
  - shiftIR=1: tdo = IR shift bit 0, tdo_en = 1.
  - shiftDR=1: tdo = bit 0 of the selected DR chain, tdo_en = 1.
  - otherwise: tdo_en = 0 and tdo holds its previous value.
REQ-024 SHALL, when qualifiers are simultaneously active, apply priority tlreset > captureIR > shiftIR > updateIR for the IR, and captureDR > shiftDR > updateDR for the DR chains.
REQ-025 SHALL use the ir value held at the rising edge for DR selection, so an IR update never retargets a DR operation in the same edge.
REQ-026 SHALL shift indefinitely without wrap logic; bits shifted past bit 0 are lost, and bits entered after the chain length reach tdo delayed by exactly the chain length.

Reset
REQ-027 SHALL, while reset=1 and independent of clk, drive:
  - ir = 4'h1, IR shift = 4'b0101.
  - All DR shift chains = 0, user_q = 0.
  - user_upd = 0, tdo = 0, tdo_en = 0.
REQ-028 SHALL abort any shift in progress on reset, including mid-shift; the first rising clk after deassertion obeys the qualifiers normally.
REQ-029 SHALL NOT change ir on reset deassertion; IDCODE remains selected until the next updateIR.

Configuration
REQ-030 SHALL honour macro TAP_REGS_USER_CAPTURE_EN:
  - Defined: USER capture loads user_din.
  - Undefined: USER capture loads user_q (readback); user_din is unused.

Verification
REQ-031 SHALL cover reset then 32 DR shifts with ir=IDCODE -> tdo bits LSB-first equal 32'h1234_5001, tdo_en=1 throughout.
REQ-032 SHALL cover IR capture then 4 shifts of tdi=1,1,1,1, then updateIR -> tdo shows 1,0,1,0; ir=4'hF; a subsequent DR shift of 1,0,1 returns 0,1,0 (one-bit delay).
REQ-033 SHALL cover ir=8, USER_W=32, shift 32'hDEAD_BEEF, then updateDR -> user_q=32'hDEAD_BEEF, user_upd high exactly 1 cycle.
REQ-034 SHALL cover USER capture with user_din=32'hA5A5_0F0F -> with the macro, tdo LSB-first = A5A50F0F; without it, tdo = current user_q.
REQ-035 SHALL cover ir=8 then tlreset=1 for one rising edge -> ir=4'h1 and user_q unchanged.
REQ-036 SHALL cover reset asserted after 10 of 32 USER shift bits -> all outputs take reset values immediately; user_q=0 with no user_upd pulse.
